// File: rtl/reset_sequencer_pkg.sv
// Shared types and widths for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_RDY,
        RUN,
        FAULT
    } state_t;

    localparam int STAGE_IDX_W   = 3;   // up to 8 stages
    localparam int FAULT_STAGE_W = STAGE_IDX_W;

endpackage

// File: rtl/reset_sequencer_req_sync_edge.sv
// Two-flop synchronizer on the asynchronous reset request plus rising-edge
// detect; emits a single-cycle pulse per request.
module req_sync_edge
    import rst_seq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_pulse
);

    logic [2:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], i_req};
        end
    end

    assign o_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the weather-box peripherals with per-stage ready
// handshake. Stage timeout/FAULT logic is built only with RST_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// HOLD     | unreleased stages in reset, counting settle delay for stage k
// WAIT_RDY | stage k released, waiting for its ready
// RUN      | all stages released and ready
// FAULT    | stage k never became ready; all stages back in reset
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DLY   = 1000,
    parameter int ACK_TIMEOUT = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic [N_STAGES-1:0]      i_stage_ready,
    output logic [N_STAGES-1:0]      o_stage_rst,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_fault,
    output logic [FAULT_STAGE_W-1:0] o_fault_stage
);

    localparam logic [CNT_W-1:0]       DLY_LOAD = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0]       ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [STAGE_IDX_W-1:0] LAST_K   = STAGE_IDX_W'(N_STAGES - 1);

    state_t                 state;
    logic [STAGE_IDX_W-1:0] k;
    logic [CNT_W-1:0]       cnt;
    logic                   req_pulse;
    logic [7:0]             rdy_ext;
    logic [7:0]             k_onehot;

    req_sync_edge u_req_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .o_pulse (req_pulse)
    );

    // Widen to the full index range so k can address any bit without a width mismatch.
    assign rdy_ext  = 8'(i_stage_ready);
    assign k_onehot = 8'b1 << k;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= HOLD;
            k           <= '0;
            cnt         <= DLY_LOAD;
            o_stage_rst <= '1;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            o_fault       <= 1'b0;
            o_fault_stage <= '0;
`endif
        end else if (req_pulse) begin
            // A request outranks any ready or timeout seen in the same cycle.
            state       <= HOLD;
            k           <= '0;
            cnt         <= DLY_LOAD;
            o_stage_rst <= '1;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            o_fault       <= 1'b0;
            o_fault_stage <= '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        o_stage_rst <= o_stage_rst & ~k_onehot[N_STAGES-1:0];
                        cnt         <= ACK_LOAD;
                        state       <= WAIT_RDY;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WAIT_RDY: begin
                    if (rdy_ext[k]) begin
                        if (k == LAST_K) begin
                            state  <= RUN;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            k     <= k + STAGE_IDX_W'(1);
                            cnt   <= DLY_LOAD;
                            state <= HOLD;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt == '0) begin
                        state         <= FAULT;
                        o_stage_rst   <= '1;
                        o_busy        <= 1'b0;
                        o_fault       <= 1'b1;
                        o_fault_stage <= k;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef RST_SEQ_TIMEOUT_EN
    assign o_fault       = 1'b0;
    assign o_fault_stage = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized self-checking bench for reset_sequencer; expected outputs come
// from a per-scenario timeline of release/ready/fault edges.
module tb_reset_sequencer;

    localparam int N     = 3;
    localparam int SD    = 4;
    localparam int AT    = 8;
    localparam int CW    = 16;
    localparam int NEVER = 1 << 20;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int MAXD = 9;
`else
    localparam int MAXD = 7;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_req;
    logic [N-1:0] i_stage_ready;
    logic [N-1:0] o_stage_rst;
    logic         o_busy;
    logic         o_done;
    logic         o_fault;
    logic [2:0]   o_fault_stage;

    int n_checks = 0;
    int n_fail   = 0;
    int req_left = 0;

    always #5 i_clk = ~i_clk;

    reset_sequencer #(
        .N_STAGES    (N),
        .STAGE_DLY   (SD),
        .ACK_TIMEOUT (AT),
        .CNT_W       (CW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_stage_ready (i_stage_ready),
        .o_stage_rst   (o_stage_rst),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_fault       (o_fault),
        .o_fault_stage (o_fault_stage)
    );

    task automatic check_val(input string tag, input int t,
                             input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0h, expected %0h", tag, t, act, exp);
        end
    endtask

    // Runs one sequence starting just after its start edge (t=0).
    // d[k]: cycles stage k's ready is withheld after release (ready seen on edge rel+1+d).
    // mode 0: no request; 1: request acts at end_t+arg; 2: request at a random edge.
    task automatic run_seq(input int d [N], input int mode, input int arg,
                           input int req_len, input int tail);
        int rel [N];
        int samp [N];
        int fault_t, fault_k, done_t, end_t, abort_t, last;
        bit dead;
        logic [N-1:0] rdy, e_rst;
        logic e_busy, e_done, e_fault;
        logic [2:0] e_fs;

        fault_t = -1;
        fault_k = 0;
        done_t  = -1;
        dead    = 1'b0;
        rel[0]  = SD;
        for (int k = 0; k < N; k++) begin
            if (dead) begin
                rel[k]  = NEVER;
                samp[k] = NEVER;
            end else begin
                if (k > 0) rel[k] = samp[k-1] + SD;
                samp[k] = rel[k] + 1 + d[k];
`ifdef RST_SEQ_TIMEOUT_EN
                if (d[k] >= AT) begin
                    fault_t = rel[k] + AT;
                    fault_k = k;
                    dead    = 1'b1;
                end
`endif
            end
        end
        if (!dead) done_t = samp[N-1];
        end_t = dead ? fault_t : done_t;

        case (mode)
            1:       abort_t = end_t + arg;
            2:       abort_t = int'($urandom_range(end_t + 4, 6));
            default: abort_t = 0;
        endcase
        last = (abort_t > 0) ? abort_t : end_t + tail;

        for (int t = 1; t <= last; t++) begin
            rdy = N'($urandom);
            for (int k = 0; k < N; k++)
                if (rel[k] < t && t <= samp[k]) rdy[k] = (t == samp[k]);
            if (abort_t > 0 && t == abort_t - 2) req_left = req_len;
            i_req = (req_left > 0);
            if (req_left > 0) req_left--;
            i_stage_ready = rdy;

            @(posedge i_clk);
            #1;

            if (abort_t > 0 && t == abort_t) begin
                e_rst = '1; e_busy = 1'b1; e_done = 1'b0; e_fault = 1'b0; e_fs = '0;
            end else if (fault_t >= 0 && t >= fault_t) begin
                e_rst = '1; e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b1; e_fs = 3'(fault_k);
            end else begin
                for (int k = 0; k < N; k++) e_rst[k] = (t < rel[k]);
                e_done  = (done_t >= 0 && t >= done_t);
                e_busy  = !e_done;
                e_fault = 1'b0;
                e_fs    = '0;
            end
            check_val("stage_rst", t, 32'(o_stage_rst), 32'(e_rst));
            check_val("busy_done_fault", t, 32'({o_busy, o_done, o_fault}),
                      32'({e_busy, e_done, e_fault}));
            check_val("fault_stage", t, 32'(o_fault_stage), 32'(e_fs));
        end
    endtask

    initial begin
        int dz [N];
        int dv [N];

        dz = '{default: 0};
        i_rst = 1'b1;
        i_req = 1'b0;
        i_stage_ready = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_val("reset_stage_rst", 0, 32'(o_stage_rst), 32'({N{1'b1}}));
        check_val("reset_busy_done_fault", 0, 32'({o_busy, o_done, o_fault}), 32'(3'b100));
        check_val("reset_fault_stage", 0, 32'(o_fault_stage), 32'(0));
        i_rst = 1'b0;

        // All readies immediate: releases on edges 4, 9, 14, done on 15; then restart.
        run_seq(dz, 1, 3, 1, 0);

`ifdef RST_SEQ_TIMEOUT_EN
        // Stage 1 never ready: fault, then a request out of FAULT.
        dv = '{0, NEVER, 0};
        run_seq(dv, 1, 6, 2, 0);
`else
        // Stage 0 ready withheld for 1000 cycles: no fault, then completes.
        dv = '{1000, 0, 0};
        run_seq(dv, 1, 3, 1, 0);
`endif

        // Request lands on the same edge that samples stage 2's ready.
        dv = '{0, 0, 3};
        run_seq(dv, 1, 0, 1, 0);

        // Ready-on-last-cycle boundary, then random delays and random aborts.
        dv = '{AT - 1, 0, AT - 1};
        run_seq(dv, 1, 2, 1, 0);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < N; k++) dv[k] = int'($urandom_range(MAXD, 0));
            run_seq(dv, 2, 0, int'($urandom_range(3, 1)), 0);
        end

        // Request held high for 100 cycles while in RUN: exactly one restart.
        run_seq(dz, 1, 5, 100, 0);
        run_seq(dz, 0, 0, 0, 110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
